// File: rtl/sonar_pkg.sv
// Shared types, default 50 MHz timing and channel-selection helper for the sonar scan scheduler.
package sonar_pkg;

    localparam int MAX_CH = 8;
    localparam int CH_W   = 3;

    localparam int TRIG_CYC_DEF    = 500;
    localparam int START_MAX_DEF   = 50000;
    localparam int ECHO_MAX_DEF    = 1900000;
    localparam int HOLDOFF_CYC_DEF = 3000000;
    localparam int NEAR_TH_DEF     = 30000;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT,
        MEAS,
        HOLD
    } state_e;

    // First enabled channel at or after start, wrapping at n-1; start if none is enabled.
    function automatic logic [CH_W-1:0] next_enabled(input logic [MAX_CH-1:0] mask,
                                                     input logic [CH_W-1:0] start,
                                                     input int n);
        logic [CH_W-1:0] sel;
        logic            found;
        int              idx;
        sel   = start;
        found = 1'b0;
        for (int i = 0; i < MAX_CH; i++) begin
            idx = (int'(start) + i) % n;
            if (!found && i < n && mask[idx[CH_W-1:0]]) begin
                sel   = idx[CH_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/sonar_echo_sync.sv
// Two-flop synchroniser for all echo pins, plus edge pulses on the currently selected channel.
module sonar_echo_sync
    import sonar_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] echo_i,
    input  logic [CH_W-1:0] sel_i,
    output logic            echo_s_o,
    output logic            rise_o,
    output logic            fall_o
);

    logic [N_CH-1:0]   meta_q;
    logic [N_CH-1:0]   sync_q;
    logic [MAX_CH-1:0] sync_pad;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= echo_i;
            sync_q <= meta_q;
            prev_q <= echo_s_o;
        end
    end

    assign sync_pad = MAX_CH'(sync_q);
    assign echo_s_o = sync_pad[sel_i];
    assign rise_o   = echo_s_o & ~prev_q;
    assign fall_o   = ~echo_s_o & prev_q;

endmodule

// File: rtl/sonar_scan_sched.sv
// Round-robin ultrasonic ranger scheduler: one trigger at a time, echo width measured in clk cycles.
// Optional proximity alarm output near_o is built when SONAR_PROX_ALARM_EN is defined.
module sonar_scan_sched
    import sonar_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 22,
    parameter int TRIG_CYC    = TRIG_CYC_DEF,
    parameter int START_MAX   = START_MAX_DEF,
    parameter int ECHO_MAX    = ECHO_MAX_DEF,
    parameter int HOLDOFF_CYC = HOLDOFF_CYC_DEF
`ifdef SONAR_PROX_ALARM_EN
    ,
    parameter int NEAR_TH     = NEAR_TH_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en_mask,
    input  logic [N_CH-1:0]  echo_i,
    output logic [N_CH-1:0]  trig_o,
    output logic             res_valid,
    output logic [2:0]       res_ch,
    output logic [CNT_W-1:0] res_width,
    output logic             res_timeout,
    output logic             busy
`ifdef SONAR_PROX_ALARM_EN
    ,
    output logic [N_CH-1:0]  near_o
`endif
);

    if (N_CH < 1 || N_CH > MAX_CH) begin : g_bad_nch
        $error("N_CH must be in 1..8");
    end
    if (64'(ECHO_MAX) >= (64'd1 << CNT_W) || 64'(START_MAX) >= (64'd1 << CNT_W)
        || 64'(HOLDOFF_CYC) >= (64'd1 << CNT_W)) begin : g_bad_cnt
        $error("timing limits must fit in CNT_W bits");
    end

    state_e          state_q;
    logic [CH_W-1:0] ch_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N_CH-1:0] trig_q;
    logic            busy_q;
    logic            res_valid_q;
    logic [CH_W-1:0] res_ch_q;
    logic [CNT_W-1:0] res_width_q;
    logic            res_to_q;

    logic [CH_W-1:0] nxt_ch;
    logic [CH_W-1:0] adv_ch;
    logic [CNT_W-1:0] cnt_inc;
    logic            echo_s;
    logic            echo_rise;
    logic            echo_fall;

    sonar_echo_sync #(.N_CH(N_CH)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .echo_i   (echo_i),
        .sel_i    (ch_ptr_q),
        .echo_s_o (echo_s),
        .rise_o   (echo_rise),
        .fall_o   (echo_fall)
    );

    assign nxt_ch  = next_enabled(MAX_CH'(en_mask), ch_ptr_q, N_CH);
    assign adv_ch  = (ch_ptr_q == CH_W'(N_CH - 1)) ? '0 : ch_ptr_q + 1'b1;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_ptr_q    <= '0;
            cnt_q       <= '0;
            trig_q      <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_width_q <= '0;
            res_to_q    <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (en_mask != '0) begin
                    ch_ptr_q <= nxt_ch;
                    trig_q   <= N_CH'(1) << nxt_ch;
                    cnt_q    <= '0;
                    busy_q   <= 1'b1;
                    state_q  <= TRIG;
                end
                TRIG: if (cnt_q == CNT_W'(TRIG_CYC - 1)) begin
                    trig_q  <= '0;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end else begin
                    cnt_q <= cnt_inc;
                end
                // Level check also catches an echo that was already high on entry.
                // The rise cycle itself is the first high cycle, so counting starts at 1.
                WAIT: if (echo_rise || echo_s) begin
                    cnt_q   <= CNT_W'(1);
                    state_q <= MEAS;
                end else if (cnt_q == CNT_W'(START_MAX - 1)) begin
                    res_valid_q <= 1'b1;
                    res_ch_q    <= ch_ptr_q;
                    res_width_q <= '0;
                    res_to_q    <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= HOLD;
                end else begin
                    cnt_q <= cnt_inc;
                end
                MEAS: if (echo_fall) begin
                    res_valid_q <= 1'b1;
                    res_ch_q    <= ch_ptr_q;
                    res_width_q <= cnt_q;
                    res_to_q    <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= HOLD;
                end else if (cnt_q == CNT_W'(ECHO_MAX)) begin
                    res_valid_q <= 1'b1;
                    res_ch_q    <= ch_ptr_q;
                    res_width_q <= '0;
                    res_to_q    <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= HOLD;
                end else begin
                    cnt_q <= cnt_inc;
                end
                HOLD: if (cnt_q == CNT_W'(HOLDOFF_CYC - 1)) begin
                    ch_ptr_q <= adv_ch;
                    cnt_q    <= '0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end else begin
                    cnt_q <= cnt_inc;
                end
                default: begin
                    trig_q  <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign trig_o      = trig_q;
    assign busy        = busy_q;
    assign res_valid   = res_valid_q;
    assign res_ch      = res_ch_q;
    assign res_width   = res_width_q;
    assign res_timeout = res_to_q;

`ifdef SONAR_PROX_ALARM_EN
    logic [N_CH-1:0]      near_q;
    logic [N_CH-1:0][2:0] far_hist_q;

    // A near bit clears only after three consecutive far-or-timeout results on that channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            near_q     <= '0;
            far_hist_q <= '0;
        end else if (res_valid_q) begin
            for (int i = 0; i < N_CH; i++) begin
                if (res_ch_q == CH_W'(i)) begin
                    if (!res_to_q && res_width_q < CNT_W'(NEAR_TH)) begin
                        near_q[i]     <= 1'b1;
                        far_hist_q[i] <= '0;
                    end else begin
                        far_hist_q[i] <= {far_hist_q[i][1:0], 1'b1};
                        if (far_hist_q[i][1:0] == 2'b11) near_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign near_o = near_q;
`endif

endmodule

// File: tb/tb_sonar_scan_sched.sv
// Directed bench for sonar_scan_sched: sensor echo model, scoreboard of expected results, trigger monitor.
module tb_sonar_scan_sched;

    localparam int N_CH = 4, CNT_W = 22, TRIG_CYC = 5, START_MAX = 40, ECHO_MAX = 200, HOLDOFF_CYC = 20;
    localparam int ECHO_DLY = 10, ECHO_LEN = 50;
    localparam int M_NORM = 0, M_NEVER = 1, M_STUCK = 2;
    // Cycles from trigger fall to res_valid: 2-flop sync plus registered emission.
    localparam int LAT_ECHO = ECHO_DLY + ECHO_LEN + 3;
    localparam int LAT_NOECHO = START_MAX;
    localparam int LAT_STUCK = ECHO_MAX + 1;

    typedef struct {
        int ch;
        int width;
        int to;
        int lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_CH-1:0]  en_mask = '0;
    logic [N_CH-1:0]  echo_i = '0;
    logic [N_CH-1:0]  trig_o;
    logic             res_valid;
    logic [2:0]       res_ch;
    logic [CNT_W-1:0] res_width;
    logic             res_timeout;
    logic             busy;
`ifdef SONAR_PROX_ALARM_EN
    logic [N_CH-1:0]  near_o;
`endif

    int n_chk = 0, n_err = 0;
    exp_t sb[$];
    logic [N_CH-1:0] forbid = '0;
    int mode [N_CH] = '{default: 0};
    int rise_cd [N_CH] = '{default: 0};
    int high_cd [N_CH] = '{default: 0};
    logic [N_CH-1:0] mdl_prev = '0;

    sonar_scan_sched #(
        .N_CH(N_CH), .CNT_W(CNT_W), .TRIG_CYC(TRIG_CYC), .START_MAX(START_MAX),
        .ECHO_MAX(ECHO_MAX), .HOLDOFF_CYC(HOLDOFF_CYC)
    ) dut (
        .clk(clk), .rst(rst), .en_mask(en_mask), .echo_i(echo_i), .trig_o(trig_o),
        .res_valid(res_valid), .res_ch(res_ch), .res_width(res_width),
        .res_timeout(res_timeout), .busy(busy)
`ifdef SONAR_PROX_ALARM_EN
        , .near_o(near_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input int w, input int to, input int lat);
        exp_t e;
        e.ch = ch; e.width = w; e.to = to; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    // Sensor model: a normal sensor answers each trigger fall with a delayed fixed-width echo.
    always @(negedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (high_cd[c] > 0) high_cd[c]--;
            if (rise_cd[c] > 0) begin
                rise_cd[c]--;
                if (rise_cd[c] == 0) high_cd[c] = ECHO_LEN;
            end
            if (mdl_prev[c] && !trig_o[c] && mode[c] == M_NORM) rise_cd[c] = ECHO_DLY;
            mdl_prev[c] = trig_o[c];
            echo_i[c] = (mode[c] == M_STUCK) || (high_cd[c] > 0);
        end
    end

    // Monitor: trigger shape/spacing and scoreboard comparison of every result strobe.
    int cyc = 0, last_res_cyc = 0;
    bit have_res = 0;
    int hi_cnt [N_CH] = '{default: 0};
    int fall_cyc [N_CH] = '{default: 0};
    logic [N_CH-1:0] mon_prev = '0;
    exp_t mon_e;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            have_res = 0;
            mon_prev = '0;
        end else begin
            if (trig_o != '0) begin
                check("trig_onehot", 32'($onehot(trig_o)), 1);
                check("trig_masked", 32'(trig_o & forbid), 0);
            end
            for (int c = 0; c < N_CH; c++) begin
                if (trig_o[c] && !mon_prev[c]) begin
                    if (have_res) check("res_to_trig_gap", cyc - last_res_cyc, HOLDOFF_CYC + 1);
                    hi_cnt[c] = 0;
                end
                if (trig_o[c]) hi_cnt[c]++;
                if (!trig_o[c] && mon_prev[c]) begin
                    check("trig_width", hi_cnt[c], TRIG_CYC);
                    fall_cyc[c] = cyc;
                end
            end
            mon_prev = trig_o;
            if (res_valid) begin
                check("res_expected", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("res_ch", res_ch, mon_e.ch);
                    check("res_width", res_width, mon_e.width);
                    check("res_timeout", res_timeout, mon_e.to);
                    check("res_latency", cyc - fall_cyc[mon_e.ch], mon_e.lat);
                end
                last_res_cyc = cyc;
                have_res = 1;
            end
        end
    end

    initial begin
        int n;
        bit busy_seen;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_trig", trig_o, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_ch", res_ch, 0);
        check("rst_width", res_width, 0);
        check("rst_timeout", res_timeout, 0);
        rst = 1'b0;

        // Empty mask: scheduler must stay idle.
        busy_seen = 0;
        repeat (40) begin
            @(negedge clk);
            busy_seen |= busy;
        end
        check("idle_busy", busy_seen, 0);

        en_mask = 4'b1000;
        n = 0;
        while (trig_o !== 4'b1000 && n < 2) begin
            @(negedge clk);
            n++;
        end
        check("mask_start_ch3", trig_o, 4'b1000);
        check("busy_scan", busy, 1);

        // Full scan, continuing from ch3 and wrapping.
        en_mask = 4'b1111;
        push(3, ECHO_LEN, 0, LAT_ECHO);
        for (int i = 0; i < 4; i++) push(i, ECHO_LEN, 0, LAT_ECHO);
        push(0, ECHO_LEN, 0, LAT_ECHO);
        drain("drain_full_scan");

        // Sparse mask: only ch2 and ch0, alternating.
        en_mask = 4'b0101;
        forbid  = 4'b1010;
        push(2, ECHO_LEN, 0, LAT_ECHO);
        push(0, ECHO_LEN, 0, LAT_ECHO);
        push(2, ECHO_LEN, 0, LAT_ECHO);
        push(0, ECHO_LEN, 0, LAT_ECHO);
        drain("drain_sparse");

        // Silent ch1 and stuck-high ch3 both time out; scan keeps going.
        en_mask = 4'b1111;
        forbid  = '0;
        mode[1] = M_NEVER;
        mode[3] = M_STUCK;
        push(1, 0, 1, LAT_NOECHO);
        push(2, ECHO_LEN, 0, LAT_ECHO);
        push(3, 0, 1, LAT_STUCK);
        push(0, ECHO_LEN, 0, LAT_ECHO);
        drain("drain_timeouts");

        // Reset in the middle of a ch2 measurement.
        mode[1] = M_NORM;
        mode[3] = M_NORM;
        push(1, ECHO_LEN, 0, LAT_ECHO);
        n = 0;
        while (!trig_o[2] && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("ch2_trig_seen", trig_o[2], 1);
        n = 0;
        while (trig_o[2] && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (30) @(negedge clk);
        check("ch2_busy_meas", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_trig", trig_o, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", res_valid, 0);
        check("midrst_sb_empty", sb.size(), 0);
        rst = 1'b0;
        push(0, ECHO_LEN, 0, LAT_ECHO);
        n = 0;
        while (trig_o !== 4'b0001 && n < 3) begin
            @(negedge clk);
            n++;
        end
        check("restart_ch0", trig_o, 4'b0001);
        drain("drain_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
